// File: rtl/disp_pkg.sv
// Shared types, segment codes and the double-dabble step for the
// setpoint display.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One iteration: add 3 to BCD nibbles >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] a;
    a = sr;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5)
        a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// done is high for the single COMMIT cycle; start there restarts at once.
module bin2bcd8
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_e r_state;
  logic [19:0] r_sr;
  logic [2:0]  r_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= {12'd0, value};
            r_iter  <= '0;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_sr   <= dd_step(r_sr);
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7)
            r_state <= COMMIT;
        end
        COMMIT: begin
          if (start) begin
            r_sr    <= {12'd0, value};
            r_iter  <= '0;
            r_state <= CONVERT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == COMMIT);
  assign hundreds = r_sr[19:16];
  assign tens     = r_sr[15:12];
  assign ones     = r_sr[11:8];

endmodule

// File: rtl/setpoint_display.sv
// 3-digit setpoint display: captures value, converts to BCD, scans 4 digits.
// Define DISP_UNIT_EN to show a 'C' unit glyph on digit 3 instead of blank.
module setpoint_display
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            value,
  input  logic                  update,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam logic [15:0] LP_LAST = 16'(SCAN_DIV - 1);

  logic       w_conv_busy;
  logic       w_done;
  logic       w_start;
  logic [7:0] w_conv_val;
  logic [3:0] w_h, w_t, w_o;

  logic       r_pending;
  logic [7:0] r_hold;
  logic       r_busy;
  logic [3:0] r_hund, r_tens, r_ones;

  logic [15:0] r_presc;
  logic [1:0]  r_idx;
  logic        w_wrap;
  logic [1:0]  w_idx_next;
  logic [6:0]  w_seg;

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  // A strobe landing on COMMIT restarts directly with the fresh value.
  assign w_start = (update && !w_conv_busy) ||
                   (w_done && (r_pending || update));
  assign w_conv_val = (w_done && !update) ? r_hold : value;

  bin2bcd8 u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .value    (w_conv_val),
    .busy     (w_conv_busy),
    .done     (w_done),
    .hundreds (w_h),
    .tens     (w_t),
    .ones     (w_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_hund    <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
    end else begin
      r_busy <= w_conv_busy;
      if (w_done) begin
        r_pending <= 1'b0;
        r_hund    <= w_h;
        r_tens    <= w_t;
        r_ones    <= w_o;
      end else if (update && w_conv_busy) begin
        r_pending <= 1'b1;
        r_hold    <= value;
      end
    end
  end

  assign w_wrap     = (r_presc == LP_LAST);
  assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

  always_comb begin
    w_seg = SEG_BLANK;
    case (w_idx_next)
      2'd0: w_seg = seg_of(r_ones);
      2'd1: begin
        if (r_hund != 4'd0 || r_tens != 4'd0)
          w_seg = seg_of(r_tens);
      end
      2'd2: begin
        if (r_hund != 4'd0)
          w_seg = seg_of(r_hund);
      end
      default: begin
`ifdef DISP_UNIT_EN
        w_seg = SEG_C;
`else
        w_seg = SEG_BLANK;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
    end else begin
      r_presc <= w_wrap ? 16'd0 : r_presc + 16'd1;
      r_idx   <= w_idx_next;
      r_an    <= ~(NUM_DIGITS'(1) << w_idx_next);
      r_seg   <= w_seg;
    end
  end

  assign busy = r_busy;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_setpoint_display.sv
// Directed self-checking bench for setpoint_display (SCAN_DIV = 4).
// Digit 3 expectation follows DISP_UNIT_EN.
module tb_setpoint_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = '0;
  logic       update = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  setpoint_display #(.SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .value  (value),
    .update (update),
    .busy   (busy),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

`ifdef DISP_UNIT_EN
  localparam logic [6:0] D3 = 7'b1000110;
`else
  localparam logic [6:0] D3 = 7'b1111111;
`endif

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for the digit currently enabled on an.
  function automatic logic [6:0] exp_seg(input logic [3:0] a, input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (a)
      4'b1110: return code(o);
      4'b1101: return (h == 0 && t == 0) ? 7'b1111111 : code(t);
      4'b1011: return (h == 0) ? 7'b1111111 : code(h);
      4'b0111: return D3;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0 || dp !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold: an=%b seg=%b busy=%b dp=%b, want 1111 1111111 0 1",
                 an, seg, busy, dp);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (k < 4 && (an !== 4'b1110 || seg !== 7'b1000000 || busy !== 1'b0)) begin
        errors++;
        $display("FAIL reset_release k=%0d: an=%b seg=%b busy=%b, want 1110 1000000 0",
                 k, an, seg, busy);
      end
      if (k == 4 && an !== 4'b1101) begin
        errors++;
        $display("FAIL scan_advance: an=%b, want 1101", an);
      end
    end
  endtask

  task automatic test_255;
    @(negedge clk);
    value = 8'd255;
    update = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      if (k == 0) update = 1'b0;
      checks++;
      if (busy !== (k >= 1 && k <= 9)) begin
        errors++;
        $display("FAIL busy_255 k=%0d: busy=%b", k, busy);
      end
      if (k >= 9) begin
        checks++;
        if (seg !== exp_seg(an, (k == 9) ? 0 : 255)) begin
          errors++;
          $display("FAIL seg_255 k=%0d an=%b: seg=%b want %b", k, an, seg,
                   exp_seg(an, (k == 9) ? 0 : 255));
        end
      end
    end
  endtask

  task automatic test_blanking;
    int vals[2] = '{7, 50};
    foreach (vals[i]) begin
      @(negedge clk);
      value = 8'(vals[i]);
      update = 1'b1;
      for (int k = 0; k <= 25; k++) begin
        @(negedge clk);
        if (k == 0) update = 1'b0;
        if (k >= 10) begin
          checks++;
          if (seg !== exp_seg(an, vals[i])) begin
            errors++;
            $display("FAIL blank_%0d an=%b: seg=%b want %b", vals[i], an, seg,
                     exp_seg(an, vals[i]));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen4 = 1'b0;
    @(negedge clk);
    value = 8'd100;
    update = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      int ev;
      @(negedge clk);
      update = 1'b0;
      if (k == 2) begin value = 8'd42; update = 1'b1; end
      if (k == 4) begin value = 8'd9;  update = 1'b1; end
      if (seg === 7'b0011001) seen4 = 1'b1;
      checks++;
      if (busy !== (k >= 1 && k <= 18)) begin
        errors++;
        $display("FAIL busy_b2b k=%0d: busy=%b", k, busy);
      end
      ev = (k < 10) ? 50 : (k < 19) ? 100 : 9;
      checks++;
      if (seg !== exp_seg(an, ev)) begin
        errors++;
        $display("FAIL seg_b2b k=%0d an=%b: seg=%b want %b", k, an, seg,
                 exp_seg(an, ev));
      end
    end
    checks++;
    if (seen4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_42_shown: seen=%b want 0", seen4);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    value = 8'd200;
    update = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      update = 1'b0;
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111) begin
          errors++;
          $display("FAIL mid_reset: busy=%b an=%b seg=%b, want 0 1111 1111111",
                   busy, an, seg);
        end
      end
      if (k >= 5) begin
        checks++;
        if (busy !== 1'b0 || seg !== exp_seg(an, 0)) begin
          errors++;
          $display("FAIL after_reset k=%0d an=%b: busy=%b seg=%b want 0 %b",
                   k, an, busy, seg, exp_seg(an, 0));
        end
      end
    end
  endtask

  task automatic test_digit3;
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an === 4'b0111) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL digit3_timeout: an=%b never 0111", an);
    end else if (seg !== D3) begin
      errors++;
      $display("FAIL digit3_seg: seg=%b want %b", seg, D3);
    end
  endtask

  initial begin
    test_reset;
    test_255;
    test_blanking;
    test_back_to_back;
    test_reset_mid;
    test_digit3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/setpoint_display.md
SETPOINT_DISPLAY -- requirements
Module: setpoint_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot in the multiplex scan (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port value, input, 8 bits: unsigned binary number to display (setpoint, 0..255).
REQ-005 SHALL have port update, input, 1 bit: single-cycle strobe requesting capture of value.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port an, output, 4 bits: active-low digit enables; an[0] is the rightmost digit.
REQ-008 SHALL have port seg, output, 7 bits: active-low segments, bit order gfedcba.
REQ-009 SHALL have port dp, output, 1 bit: active-low decimal point, held 1 (off) at all times.

Function
REQ-010 SHALL use FSM states IDLE, CONVERT, COMMIT.
REQ-011 IDLE: update=1 sampled at edge N -> latch value, clear iteration counter, enter CONVERT.
REQ-012 CONVERT SHALL perform one double-dabble iteration per cycle (add 3 to any BCD nibble >= 5, then shift left by 1), exactly 8 iterations, then enter COMMIT.
REQ-013 COMMIT SHALL copy hundreds/tens/ones nibbles into the display registers in one cycle, then return to IDLE.
REQ-014 Latency: busy high from cycle N+1 through N+9; new digits visible on seg from cycle N+10.
REQ-015 update during CONVERT/COMMIT SHALL store value in a hold register and set pending; later strobes overwrite the hold register (last value wins).
REQ-016 COMMIT with pending=1 SHALL commit current result, clear pending, and restart CONVERT from the hold register on the next cycle; busy stays high with no low gap.
REQ-017 update in the same cycle as COMMIT SHALL be treated as pending (REQ-015/016).
REQ-018 BCD arithmetic SHALL be 20 bits (12 BCD + 8 binary); 255 SHALL yield 2,5,5 with no overflow.
REQ-019 Scan: 16-bit prescaler counts 0..SCAN_DIV-1 and wraps; on wrap the 2-bit digit index advances 0->1->2->3->0.
REQ-020 an SHALL have exactly one bit low, selected by digit index; an, seg registered, changing in the same cycle.
REQ-021 Digit 0 = ones, digit 1 = tens, digit 2 = hundreds, digit 3 per REQ-026.
REQ-022 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens both 0; ones never blank.
REQ-023 Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-024 Conversion SHALL NOT disturb scanning; displayed digits change only at COMMIT.

Reset
REQ-025 rst=1 SHALL force: state IDLE, busy=0, pending=0, prescaler=0, digit index=0, display nibbles=0, an=1111, seg=1111111, dp=1; rst mid-conversion aborts it and discards hold value; first cycle after release drives an=1110, seg=1000000.

Configuration
REQ-026 Macro DISP_UNIT_EN defined: digit 3 shows 'C' (seg=1000110); undefined: digit 3 shows blank (anode still scanned, seg=1111111).

Structure
REQ-027 Package disp_pkg SHALL hold the FSM state enum, segment-code constants (0-9, blank, 'C') and NUM_DIGITS=4.
REQ-028 Conversion SHALL be sub-module bin2bcd8 (start/value in, busy/done/hundreds/tens/ones out); scan/mux logic stays in setpoint_display.

Verification
REQ-029 rst 3 cycles, release -> an=1110, seg=1000000, busy=0; with SCAN_DIV=4 an advances 1110->1101 after 4 cycles.
REQ-030 value=255, update at N -> busy high N+1..N+9; from N+10 digits 2,5,5 (seg 0100100/0010010/0010010).
REQ-031 value=7 then value=50 -> "  7" (tens/hundreds blank), then " 50" (hundreds blank, tens 0010010, ones 1000000).
REQ-032 update value=100 at N, update value=42 at N+3 and value=9 at N+5 -> 100 committed at N+9, busy stays high, 9 shown at N+19; 42 never shown.
REQ-033 rst asserted at N+4 of a conversion of 200 -> display returns to "  0", busy=0, no later commit of 200.
REQ-034 Build with and without DISP_UNIT_EN -> digit 3 seg equals 1000110 vs 1111111.
